bitplane_deserializer: RTL

Receive end of the bit-plane stream: accepts one M-bit plane per handshake (bit k of the plane belongs to lane k), least-significant plane first, and reassembles M parallel W-bit words. It sits behind any bit-serial lane engine, or in loopback benches behind the bit-plane streamer, and returns frames to word-parallel logic. The output register is double-buffered against the accumulator, so back-to-back frames stream without gaps while the consumer keeps `data_rdy` high.

---
 rtl/bitplane_pkg.sv | 14 +
 rtl/bitplane_lane_acc.sv | 27 ++
 rtl/bitplane_deserializer.sv | 103 ++++++++++
 3 files changed

// File: rtl/bitplane_pkg.sv
// rtl/bitplane_pkg.sv - shared definitions for the bit-plane streamer and deserializer
package bitplane_pkg;

  localparam int BITPLANE_M_DEFAULT = 32;
  localparam int BITPLANE_W_DEFAULT = 32;

  typedef enum logic {
    COLLECT = 1'b0,
    STALL   = 1'b1
  } bp_state_e;

  typedef logic [15:0] frame_cnt_t;

endpackage

// File: rtl/bitplane_lane_acc.sv
// rtl/bitplane_lane_acc.sv - one lane's W-bit shift accumulator; new bits enter at the MSB
module bitplane_lane_acc #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift_en,
  input  logic         lane_bit,
  output logic [W-1:0] shifted_word
);

  logic [W-1:0] acc_q;
  logic         unused_lsb;

  // Parallel read already includes the incoming bit so the last plane lands in the frame directly.
  assign shifted_word = {lane_bit, acc_q[W-1:1]};
  assign unused_lsb   = acc_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (shift_en) begin
      acc_q <= shifted_word;
    end
  end

endmodule

// File: rtl/bitplane_deserializer.sv
// rtl/bitplane_deserializer.sv - reassembles M parallel W-bit words from LSB-first bit planes
// Optional framing check: define BITPLANE_FRAME_CHECK_EN.
module bitplane_deserializer
  import bitplane_pkg::*;
#(
  parameter int M = BITPLANE_M_DEFAULT,
  parameter int W = BITPLANE_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           plane_vld,
  input  logic [M-1:0]   plane_i,
  input  logic           plane_last,
  output logic           plane_rdy,
  output logic [M*W-1:0] data_o,
  output logic           data_vld,
  input  logic           data_rdy,
  output logic [15:0]    frame_cnt_o,
  output logic           frame_err
);

  localparam int            CW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CTR_LAST = CW'(W - 1);

  bp_state_e      state;
  logic [CW-1:0]  ctr;
  logic [CW-1:0]  ctr_next;
  frame_cnt_t     frame_cnt_q;
  logic [M*W-1:0] next_frame;
  logic           at_last;
  logic           accept;
  logic           complete;
  logic           out_hs;
  logic           abort;
  logic           err_next;
  logic           vld_next;

  // STALL is registered, so the only combinational input to plane_rdy is data_rdy.
  assign plane_rdy   = !(state == STALL && !data_rdy);
  assign frame_cnt_o = frame_cnt_q;

  for (genvar k = 0; k < M; k++) begin : g_lane
    bitplane_lane_acc #(.W(W)) u_lane (
      .clk          (clk),
      .rst_n        (rst_n),
      .shift_en     (accept),
      .lane_bit     (plane_i[k]),
      .shifted_word (next_frame[k*W +: W])
    );
  end

`ifndef BITPLANE_FRAME_CHECK_EN
  logic unused_last;
  assign unused_last = plane_last;
`endif

  always_comb begin
    at_last  = (ctr == CTR_LAST);
    accept   = plane_vld && plane_rdy;
    complete = accept && at_last;
    out_hs   = data_vld && data_rdy;
`ifdef BITPLANE_FRAME_CHECK_EN
    abort    = accept && plane_last && !at_last;
    err_next = abort || (complete && !plane_last);
`else
    abort    = 1'b0;
    err_next = 1'b0;
`endif
    ctr_next = ctr;
    if (complete || abort) begin
      ctr_next = '0;
    end else if (accept) begin
      ctr_next = ctr + 1'b1;
    end
    vld_next = data_vld;
    if (complete) begin
      vld_next = 1'b1;
    end else if (out_hs) begin
      vld_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= COLLECT;
      ctr         <= '0;
      data_o      <= '0;
      data_vld    <= 1'b0;
      frame_cnt_q <= '0;
      frame_err   <= 1'b0;
    end else begin
      ctr       <= ctr_next;
      data_vld  <= vld_next;
      frame_err <= err_next;
      if (complete) begin
        data_o      <= next_frame;
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      state <= (ctr_next == CTR_LAST && vld_next) ? STALL : COLLECT;
    end
  end

endmodule
